display_arbiter: RTL and testbench
==================================

Name: display_arbiter

Overview:
- Shares the single 4-digit 7-segment display path among N_REQ KPN process outputs.
- Selects one requester at a time (round-robin) and accepts its binary value over a valid/ready handshake.
- Converts the value to packed BCD sequentially with double-dabble, one bit per cycle.
- Presents the BCD word, with a one-cycle update pulse, to the display decoder and holds it for HOLD_CYCLES before arbitrating again.

Parameters:
- N_REQ, 4: number of requesters (2..8).
- ID_W, 2: width of src_id; must be >= clog2(N_REQ).
- DATA_W, 14: width of each binary input value.
- HOLD_CYCLES, 50000000: clk cycles each result is held before the next arbitration; minimum 1.
- CNT_W, 26: hold-counter width; must satisfy 2^CNT_W > HOLD_CYCLES.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  N_REQ  bit i set: requester i has data.
- req_data  in  N_REQ*DATA_W  requester i value at bits [i*DATA_W +: DATA_W].
- req_ready  out  N_REQ  one-hot grant; a transfer occurs when req_valid[i] & req_ready[i] at a rising edge.
- bcd_out  out  16  packed BCD {thousands, hundreds, tens, ones}; feeds the 16-bit display entry.
- src_id  out  ID_W  index of the requester whose value is on bcd_out.
- bcd_update  out  1  one-cycle pulse when bcd_out/src_id change.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset (async assert, sync release):
  - State IDLE; rr_last = N_REQ-1, so requester 0 has top priority first.
  - bcd_out = 16'h0000, src_id = 0, bcd_update = 0, busy = 0, req_ready = 0.
  - Hold counter = 0 and shift registers cleared.
  - Reset mid-CONVERT or mid-SHOW aborts the operation. No partial result reaches bcd_out, and the aborted requester is not re-granted automatically.
- State IDLE:
  - Grant is combinational. Scan indices rr_last+1, rr_last+2, … modulo N_REQ; the first index with req_valid set wins.
  - req_ready[winner] = 1 and all other bits = 0. If no request is valid, req_ready = 0 and the block stays in IDLE with outputs held.
  - On the accepting edge:
    - Latch req_data[winner] and saturate it to 9999 if it exceeds 9999.
    - Set rr_last = winner and latch winner as pending id.
    - Go to CONVERT.
  - Requesters hold req_data stable while req_valid is high and not yet accepted. Dropping req_valid before acceptance withdraws the request legally.
- State CONVERT:
  - Exactly DATA_W cycles of double-dabble.
  - Each cycle, every BCD nibble >= 5 gets +3, then {bcd, bin} shifts left by 1, with the binary MSB first.
  - Iteration counter counts DATA_W-1 down to 0.
  - On the edge leaving CONVERT:
    - bcd_out and src_id load the result.
    - bcd_update = 1 for that one following cycle.
    - State becomes SHOW and the hold counter loads HOLD_CYCLES-1.
  - req_ready = 0 throughout CONVERT.
- State SHOW:
  - Counter decrements each cycle; at 0 the state returns to IDLE. SHOW lasts exactly HOLD_CYCLES cycles.
  - req_ready = 0.
- Timing:
  - Latency from accepting edge to bcd_out update edge is DATA_W cycles.
  - Minimum spacing between accepts is 1 + DATA_W + HOLD_CYCLES cycles.
- Outputs hold after SHOW; the display never blanks. bcd_out nibbles are always in 0..9.
- Equal-value back-to-back results still pulse bcd_update.
- All-requesters-valid case: grants rotate 0,1,2,3,0,… so no requester starves.

Test Plan (bench uses DATA_W=14, HOLD_CYCLES=4, N_REQ=4):
- Reset then idle: no req_valid for 20 cycles -> bcd_out = 0000, busy = 0, req_ready = 0, no bcd_update.
- Single request: req_valid[2] = 1, data = 1234 -> req_ready = 4'b0100 in the same cycle. 14 cycles after accept, bcd_out = 16'h1234 and src_id = 2 with a one-cycle bcd_update. busy falls 4 cycles later.
- Saturation and boundaries:
  - 9999 -> 16'h9999.
  - 16383 -> 16'h9999.
  - 0 -> 16'h0000.
  - 10 -> 16'h0010.
- Round-robin fairness: all four valid continuously with data = 1000*i + 7 -> src_id sequence 0,1,2,3,0 and bcd_out 0007, 1007, 2007, 3007.
- Withdrawal and skip: req0 valid, dropped before grant while busy; req3 valid -> next grant goes to req3, and req0 is never acknowledged.
- Reset mid-operation: assert rst_n = 0 during CONVERT of 4321 -> bcd_out = 0000 and busy = 0 immediately; after release, req0 has priority.

Source files
------------

// File: rtl/display_arbiter.sv
// -----------------------------------------------------------------------------
// display_arbiter
//
// Shares one 4-digit 7-segment display path among N_REQ producer processes.
// One requester at a time is granted (round-robin). Its binary value is taken
// over a valid/ready handshake, clamped to 9999, and converted to packed BCD
// with a sequential double-dabble (one bit per cycle). The result is then
// presented with a one-cycle update pulse and held for HOLD_CYCLES cycles
// before the next arbitration.
//
// Handshake: a transfer from requester i happens on a rising edge where
// i_req_valid[i] & o_req_ready[i] are both high. o_req_ready is a
// combinational one-hot grant that is only non-zero in IDLE. A requester keeps
// its data stable while valid is high and not yet accepted. It may drop valid
// before acceptance to withdraw the request.
//
// Ports:
//   i_clk         system clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_req_valid   [N_REQ]          request valid per requester
//   i_req_data    [N_REQ*DATA_W]   requester i value at [i*DATA_W +: DATA_W]
//   o_req_ready   [N_REQ]          one-hot grant (IDLE only)
//   o_bcd_out     [16]             packed BCD {thousands,hundreds,tens,ones}
//   o_src_id      [ID_W]           requester whose value is on o_bcd_out
//   o_bcd_update  1                one-cycle pulse when o_bcd_out/o_src_id load
//   o_busy        1                high whenever the FSM is not in IDLE
//   o_dbg_state   [2]              FSM state (0 IDLE, 1 CONVERT, 2 SHOW)
// -----------------------------------------------------------------------------
module display_arbiter #(
   parameter int N_REQ       = 4,
   parameter int ID_W        = 2,
   parameter int DATA_W      = 14,
   parameter int HOLD_CYCLES = 50000000,
   parameter int CNT_W       = 26
) (
   input  logic                    i_clk,
   input  logic                    i_rst_n,
   input  logic [N_REQ-1:0]        i_req_valid,
   input  logic [N_REQ*DATA_W-1:0] i_req_data,
   output logic [N_REQ-1:0]        o_req_ready,
   output logic [15:0]             o_bcd_out,
   output logic [ID_W-1:0]         o_src_id,
   output logic                    o_bcd_update,
   output logic                    o_busy,
   output logic [1:0]              o_dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_CONVERT = 2'd1,
      S_SHOW    = 2'd2
   } state_t;

   localparam int IT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

   // --------------------------------------------------------------------------
   // Registers
   // --------------------------------------------------------------------------
   state_t            r_state;
   logic [ID_W-1:0]   r_rr_last;     // last granted index; scan starts after it
   logic [ID_W-1:0]   r_pend_id;     // id of the value being converted
   logic [DATA_W-1:0] r_bin;         // binary shift register (MSB shifted out)
   logic [15:0]       r_bcd;         // BCD accumulator
   logic [IT_W-1:0]   r_iter;        // conversion steps remaining minus one
   logic [CNT_W-1:0]  r_hold_cnt;    // SHOW cycles remaining minus one
   logic [15:0]       r_bcd_out;
   logic [ID_W-1:0]   r_src_id;
   logic              r_update;

   // --------------------------------------------------------------------------
   // Combinational signals
   // --------------------------------------------------------------------------
   state_t            w_state_nxt;
   logic              w_found;
   logic [ID_W-1:0]   w_win;
   logic [N_REQ-1:0]  w_grant_oh;
   logic [DATA_W-1:0] w_sel_data;
   logic [DATA_W-1:0] w_sat_data;
   logic [15:0]       w_bcd_adj;
   logic [15:0]       w_bcd_shift;
   logic              w_conv_last;
   logic              w_show_last;

   // --------------------------------------------------------------------------
   // Round-robin winner: scan rr_last+1, rr_last+2, ... modulo N_REQ and take
   // the first valid requester. The shift-based bit pick keeps the index
   // arithmetic in plain integers for any N_REQ.
   // --------------------------------------------------------------------------
   always_comb begin
      int               v_idx;
      logic [N_REQ-1:0] v_shifted;
      w_found   = 1'b0;
      w_win     = '0;
      v_idx     = 0;
      v_shifted = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         v_idx     = (int'(r_rr_last) + k) % N_REQ;
         v_shifted = i_req_valid >> v_idx;
         if (!w_found && v_shifted[0]) begin
            w_found = 1'b1;
            w_win   = ID_W'(v_idx);
         end
      end
   end

   // One-hot grant for the winner; only presented while IDLE.
   always_comb begin
      w_grant_oh  = '0;
      o_req_ready = '0;
      if (w_found) begin
         w_grant_oh = {{(N_REQ-1){1'b0}}, 1'b1} << w_win;
      end
      if (r_state == S_IDLE) begin
         o_req_ready = w_grant_oh;
      end
   end

   // Winner's data, clamped so the result always fits in four BCD digits.
   always_comb begin
      logic [N_REQ*DATA_W-1:0] v_data_sh;
      v_data_sh  = i_req_data >> (int'(w_win) * DATA_W);
      w_sel_data = v_data_sh[DATA_W-1:0];
      w_sat_data = w_sel_data;
      if (32'(w_sel_data) > 32'd9999) begin
         w_sat_data = DATA_W'(32'd9999);
      end
   end

   // --------------------------------------------------------------------------
   // One double-dabble step: add 3 to every nibble >= 5, then shift
   // {bcd, bin} left by one with the binary MSB entering the BCD LSB.
   // Because the input is clamped to 9999 the top nibble never overflows.
   // --------------------------------------------------------------------------
   always_comb begin
      w_bcd_adj = r_bcd;
      for (int n = 0; n < 4; n++) begin
         if (r_bcd[n*4 +: 4] >= 4'd5) begin
            w_bcd_adj[n*4 +: 4] = r_bcd[n*4 +: 4] + 4'd3;
         end
      end
      w_bcd_shift = {w_bcd_adj[14:0], r_bin[DATA_W-1]};
   end

   assign w_conv_last = (r_iter == '0);
   assign w_show_last = (r_hold_cnt == '0);

   // --------------------------------------------------------------------------
   // FSM: state register
   // --------------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // FSM: next state
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_state_nxt = S_CONVERT;
            end
         end
         S_CONVERT: begin
            if (w_conv_last) begin
               w_state_nxt = S_SHOW;
            end
         end
         S_SHOW: begin
            if (w_show_last) begin
               w_state_nxt = S_IDLE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   // --------------------------------------------------------------------------
   // Datapath. A reset in the middle of a conversion or hold simply clears
   // everything; the displayed word returns to 0000 and nothing half-converted
   // is ever loaded into the output register.
   // --------------------------------------------------------------------------
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rr_last  <= ID_W'(N_REQ - 1);
         r_pend_id  <= '0;
         r_bin      <= '0;
         r_bcd      <= '0;
         r_iter     <= '0;
         r_hold_cnt <= '0;
         r_bcd_out  <= '0;
         r_src_id   <= '0;
         r_update   <= 1'b0;
      end else begin
         r_update <= 1'b0;
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_bin     <= w_sat_data;
                  r_bcd     <= '0;
                  r_iter    <= IT_W'(DATA_W - 1);
                  r_rr_last <= w_win;
                  r_pend_id <= w_win;
               end
            end
            S_CONVERT: begin
               r_bin <= r_bin << 1;
               r_bcd <= w_bcd_shift;
               if (w_conv_last) begin
                  // Final step: the shifted value is the finished result.
                  r_bcd_out  <= w_bcd_shift;
                  r_src_id   <= r_pend_id;
                  r_update   <= 1'b1;
                  r_hold_cnt <= CNT_W'(HOLD_CYCLES - 1);
               end else begin
                  r_iter <= r_iter - IT_W'(1);
               end
            end
            S_SHOW: begin
               if (!w_show_last) begin
                  r_hold_cnt <= r_hold_cnt - CNT_W'(1);
               end
            end
            default: begin
            end
         endcase
      end
   end

   // --------------------------------------------------------------------------
   // Outputs
   // --------------------------------------------------------------------------
   assign o_bcd_out    = r_bcd_out;
   assign o_src_id     = r_src_id;
   assign o_bcd_update = r_update;
   assign o_busy       = (r_state != S_IDLE);
   assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_display_arbiter.sv
// -----------------------------------------------------------------------------
// tb_display_arbiter
//
// Randomised and directed stimulus for display_arbiter (N_REQ=4, DATA_W=14,
// HOLD_CYCLES=4). A reference model samples the inputs every falling edge,
// predicts the grant from the round-robin rule, and pushes the expected
// {src_id, BCD} word (computed with decimal arithmetic) plus its expected
// arrival cycle into a queue. A separate monitor pops and compares whenever
// the DUT pulses bcd_update, and checks that the display holds otherwise.
// -----------------------------------------------------------------------------
module tb_display_arbiter;

  localparam int N_REQ  = 4;
  localparam int ID_W   = 2;
  localparam int DATA_W = 14;
  localparam int HOLD   = 4;
  localparam int CNT_W  = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  // DUT signals
  logic                    tb_valid [N_REQ];
  logic [DATA_W-1:0]       tb_data  [N_REQ];
  logic [N_REQ-1:0]        req_valid;
  logic [N_REQ*DATA_W-1:0] req_data;
  logic [N_REQ-1:0]        o_req_ready;
  logic [15:0]             o_bcd_out;
  logic [ID_W-1:0]         o_src_id;
  logic                    o_bcd_update;
  logic                    o_busy;
  logic [1:0]              o_dbg_state;

  always_comb begin
    req_valid = '0;
    req_data  = '0;
    for (int i = 0; i < N_REQ; i++) begin
      req_valid[i]                 = tb_valid[i];
      req_data[i*DATA_W +: DATA_W] = tb_data[i];
    end
  end

  display_arbiter #(
    .N_REQ(N_REQ), .ID_W(ID_W), .DATA_W(DATA_W),
    .HOLD_CYCLES(HOLD), .CNT_W(CNT_W)
  ) dut (
    .i_clk(clk),
    .i_rst_n(rst_n),
    .i_req_valid(req_valid),
    .i_req_data(req_data),
    .o_req_ready(o_req_ready),
    .o_bcd_out(o_bcd_out),
    .o_src_id(o_src_id),
    .o_bcd_update(o_bcd_update),
    .o_busy(o_busy),
    .o_dbg_state(o_dbg_state)
  );

  // bookkeeping
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // reference conversion: clamp, then split into decimal digits
  function automatic logic [15:0] to_bcd(input int v);
    int s;
    s = (v > 9999) ? 9999 : v;
    return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
  endfunction

  // scoreboard
  logic [ID_W+15:0] exp_q[$];
  int               exp_cyc_q[$];
  logic [ID_W-1:0]  seen_ids[$];

  // reference model (grant prediction, busy window)
  int m_rr = N_REQ - 1;
  int m_busy_left = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      check("rst_busy", o_busy, 0);
      check("rst_ready", o_req_ready, 0);
      check("rst_bcd", o_bcd_out, 0);
      check("rst_src", o_src_id, 0);
      check("rst_update", o_bcd_update, 0);
      m_rr = N_REQ - 1;
      m_busy_left = 0;
      exp_q.delete();
      exp_cyc_q.delete();
    end else if (m_busy_left > 0) begin
      check("busy_high", o_busy, 1);
      check("ready_while_busy", o_req_ready, 0);
      m_busy_left--;
    end else begin
      int win;
      bit found;
      logic [N_REQ-1:0] exp_ready;
      found = 1'b0;
      win = 0;
      for (int k = 1; k <= N_REQ; k++) begin
        int idx;
        idx = (m_rr + k) % N_REQ;
        if (!found && tb_valid[idx]) begin
          found = 1'b1;
          win = idx;
        end
      end
      exp_ready = found ? (4'b0001 << win) : 4'b0000;
      check("busy_low", o_busy, 0);
      check("grant", o_req_ready, exp_ready);
      if (found) begin
        exp_q.push_back({ID_W'(win), to_bcd(int'(tb_data[win]))});
        exp_cyc_q.push_back(cyc + 1 + DATA_W);
        m_rr = win;
        m_busy_left = DATA_W + HOLD;
      end
    end
  end

  // monitor
  logic [15:0]     m_disp = '0;
  logic [ID_W-1:0] m_src  = '0;

  always @(negedge clk) begin
    if (!rst_n) begin
      m_disp = '0;
      m_src  = '0;
    end else if (o_bcd_update) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_update: got bcd %0h src %0d expected no update (cycle %0d)",
                 o_bcd_out, o_src_id, cyc);
      end else begin
        logic [ID_W+15:0] e;
        int ec;
        e  = exp_q.pop_front();
        ec = exp_cyc_q.pop_front();
        check("bcd_out", o_bcd_out, e[15:0]);
        check("src_id", o_src_id, e[ID_W+15:16]);
        check("latency", cyc, ec);
        m_disp = e[15:0];
        m_src  = e[ID_W+15:16];
        seen_ids.push_back(o_src_id);
      end
    end else begin
      check("hold_bcd", o_bcd_out, m_disp);
      check("hold_src", o_src_id, m_src);
    end
  end

  // driver tasks (all return at posedge+1)
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input int idx);
    bit got;
    int n;
    got = 1'b0;
    n = 0;
    while (!got && n < 200) begin
      @(negedge clk);
      if (o_req_ready[idx] && tb_valid[idx]) got = 1'b1;
      step();
      n++;
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL grant_timeout: got no grant for req %0d expected one within 200 cycles", idx);
    end
  endtask

  task automatic wait_idle();
    bit idle;
    int n;
    idle = 1'b0;
    n = 0;
    while (!idle && n < 200) begin
      @(negedge clk);
      if (!o_busy) idle = 1'b1;
      step();
      n++;
    end
    if (!idle) begin
      checks++;
      errors++;
      $display("FAIL idle_timeout: got busy=1 expected busy=0 within 200 cycles");
    end
  endtask

  task automatic send(input int idx, input int d);
    tb_data[idx]  = DATA_W'(d);
    tb_valid[idx] = 1'b1;
    wait_grant(idx);
    tb_valid[idx] = 1'b0;
    wait_idle();
  endtask

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000ns");
    $fatal(1, "watchdog expired");
  end

  // stimulus
  initial begin
    int grants;
    int n;
    int ack0;
    rst_n = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      tb_valid[i] = 1'b0;
      tb_data[i]  = '0;
    end
    repeat (3) step();
    rst_n = 1'b1;

    // idle: nothing requested for 20 cycles
    repeat (20) step();

    // single request
    send(2, 1234);

    // saturation and boundaries (last one from req3 so rr_last ends at 3)
    send(1, 9999);
    send(2, 16383);
    send(0, 0);
    send(3, 10);

    // randomised traffic: random subsets of requesters with random values
    for (int t = 0; t < 8; t++) begin
      int pick;
      pick = $urandom_range(0, N_REQ - 1);
      for (int i = 0; i < N_REQ; i++) begin
        tb_data[i]  = DATA_W'($urandom_range(0, 16383));
        tb_valid[i] = ($urandom_range(0, 1) == 1) || (i == pick);
      end
      wait_grant(pick);
      for (int i = 0; i < N_REQ; i++) tb_valid[i] = 1'b0;
      wait_idle();
    end
    send(3, $urandom_range(0, 9999));

    // round-robin: all four valid continuously
    seen_ids.delete();
    for (int i = 0; i < N_REQ; i++) begin
      tb_data[i]  = DATA_W'(1000 * i + 7);
      tb_valid[i] = 1'b1;
    end
    grants = 0;
    n = 0;
    while (grants < 5 && n < 500) begin
      @(negedge clk);
      if ((o_req_ready & req_valid) != '0) grants++;
      step();
      n++;
    end
    for (int i = 0; i < N_REQ; i++) tb_valid[i] = 1'b0;
    check("rr_grant_count", grants, 5);
    wait_idle();
    check("rr_update_count", seen_ids.size(), 5);
    if (seen_ids.size() == 5) begin
      check("rr_id0", seen_ids[0], 0);
      check("rr_id1", seen_ids[1], 1);
      check("rr_id2", seen_ids[2], 2);
      check("rr_id3", seen_ids[3], 3);
      check("rr_id4", seen_ids[4], 0);
    end

    // withdrawal: req0 raised while busy, dropped before any grant
    tb_data[1]  = 14'd55;
    tb_valid[1] = 1'b1;
    wait_grant(1);
    tb_valid[1] = 1'b0;
    tb_data[0]  = 14'd777;
    tb_valid[0] = 1'b1;
    ack0 = 0;
    repeat (6) begin
      @(negedge clk);
      if (o_req_ready[0]) ack0++;
      step();
    end
    tb_valid[0] = 1'b0;
    tb_data[3]  = 14'd3333;
    tb_valid[3] = 1'b1;
    wait_grant(3);
    tb_valid[3] = 1'b0;
    check("withdraw_ack0", ack0, 0);
    wait_idle();

    // reset in the middle of converting 4321
    tb_data[2]  = 14'd4321;
    tb_valid[2] = 1'b1;
    wait_grant(2);
    tb_valid[2] = 1'b0;
    repeat (5) step();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    tb_data[0]  = 14'd11;
    tb_data[3]  = 14'd3003;
    tb_valid[0] = 1'b1;
    tb_valid[3] = 1'b1;
    wait_grant(0);
    tb_valid[0] = 1'b0;
    wait_grant(3);
    tb_valid[3] = 1'b0;
    wait_idle();

    repeat (3) step();
    check("scoreboard_drained", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
